// File: rtl/card_grid_pkg.sv
// Shared types, command encodings and default geometry for the card grid renderer.
package card_grid_pkg;

  typedef enum logic [1:0] {
    CARD_HIDDEN  = 2'b00,
    CARD_SHOWN   = 2'b01,
    CARD_MATCHED = 2'b10
  } card_state_e;

  typedef enum logic [1:0] {
    ANIM_IDLE   = 2'b00,
    ANIM_SHRINK = 2'b01,
    ANIM_GROW   = 2'b10
  } anim_state_e;

  localparam logic [1:0] OP_FLIP_UP      = 2'b00;
  localparam logic [1:0] OP_FLIP_DOWN    = 2'b01;
  localparam logic [1:0] OP_MARK_MATCHED = 2'b10;
  localparam logic [1:0] OP_CLEAR_ALL    = 2'b11;

  localparam int DEF_COLS       = 4;
  localparam int DEF_ROWS       = 4;
  localparam int DEF_X0         = 130;
  localparam int DEF_Y0         = 70;
  localparam int DEF_PITCH      = 100;
  localparam int DEF_CARD_W     = 90;
  localparam int DEF_CARD_H     = 90;
  localparam int DEF_FLIP_STEPS = 8;
  localparam int DEF_RGB_W      = 3;

  // True when a local pixel lies in the outer 2-pixel ring of a card.
  function automatic logic in_ring(input logic [6:0] lcol, input logic [6:0] lrow,
                                   input int card_w, input int card_h);
    return (lcol < 7'd2) || (lcol >= 7'(card_w - 2)) ||
           (lrow < 7'd2) || (lrow >= 7'(card_h - 2));
  endfunction

endpackage

// File: rtl/card_grid_renderer_if.sv
// Command channel between the game controller and the card grid renderer.
interface card_grid_renderer_if #(
  parameter int IDX_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [IDX_W-1:0] cmd_idx;
  logic             busy;

  modport master (output cmd_valid, output cmd_op, output cmd_idx,
                  input cmd_ready, input busy);
  modport slave  (input cmd_valid, input cmd_op, input cmd_idx,
                  output cmd_ready, output busy);
endinterface

// File: rtl/card_flip_anim.sv
// Flip animator: SHRINK/GROW sequencer stepped by frame_tick, plus the
// per-frame visible width and margin of the animated card.
module card_flip_anim
  import card_grid_pkg::*;
#(
  parameter int IDX_W      = 4,
  parameter int CARD_W     = DEF_CARD_W,
  parameter int FLIP_STEPS = DEF_FLIP_STEPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             start,
  input  logic             start_open,
  input  logic [IDX_W-1:0] start_idx,
  output anim_state_e      anim_state,
  output logic [IDX_W-1:0] anim_idx,
  output logic             anim_open,
  output logic [9:0]       vis_w,
  output logic [9:0]       margin,
  output logic             commit
);
  localparam int K_W = $clog2(FLIP_STEPS + 1);

  anim_state_e      state_r, state_s;
  logic [K_W-1:0]   k_r, k_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic             open_r, open_s;
  logic [9:0]       vis_w_r, vis_w_s, margin_r, margin_s;
  logic [15:0]      prod_s;
  logic [9:0]       vis_calc_s;
  logic             commit_s;

  // Next-state, step counter and width recomputation.
  always_comb begin
    state_s    = state_r;
    k_s        = k_r;
    idx_s      = idx_r;
    open_s     = open_r;
    commit_s   = 1'b0;
    prod_s     = 16'd0;
    vis_calc_s = 10'd0;
    vis_w_s    = vis_w_r;
    margin_s   = margin_r;
    case (state_r)
      ANIM_IDLE: begin
        if (start) begin
          state_s = ANIM_SHRINK;
          k_s     = {K_W{1'b0}};
          idx_s   = start_idx;
          open_s  = start_open;
        end else begin
          state_s = ANIM_IDLE;
        end
      end
      ANIM_SHRINK: begin
        if (frame_tick) begin
          if (k_r == K_W'(FLIP_STEPS - 1)) begin
            state_s  = ANIM_GROW;
            k_s      = {K_W{1'b0}};
            commit_s = 1'b1;
          end else begin
            k_s = k_r + K_W'(1);
          end
        end else begin
          k_s = k_r;
        end
      end
      ANIM_GROW: begin
        if (frame_tick) begin
          if (k_r == K_W'(FLIP_STEPS - 1)) begin
            state_s = ANIM_IDLE;
            k_s     = {K_W{1'b0}};
          end else begin
            k_s = k_r + K_W'(1);
          end
        end else begin
          k_s = k_r;
        end
      end
      default: begin
        state_s = ANIM_IDLE;
        k_s     = {K_W{1'b0}};
      end
    endcase

    case (state_s)
      ANIM_SHRINK: prod_s = 16'(CARD_W) * (16'(FLIP_STEPS) - 16'(k_s));
      ANIM_GROW:   prod_s = 16'(CARD_W) * 16'(k_s);
      default:     prod_s = 16'(CARD_W) * 16'(FLIP_STEPS);
    endcase
    vis_calc_s = 10'(prod_s / 16'(FLIP_STEPS));

    // Width only moves on frame boundaries so a frame never tears.
    if (frame_tick) begin
      vis_w_s  = vis_calc_s;
      margin_s = (10'(CARD_W) - vis_calc_s) >> 1;
    end else begin
      vis_w_s  = vis_w_r;
      margin_s = margin_r;
    end
  end

  // Animator state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ANIM_IDLE;
      k_r      <= {K_W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      open_r   <= 1'b0;
      vis_w_r  <= 10'(CARD_W);
      margin_r <= 10'd0;
    end else begin
      state_r  <= state_s;
      k_r      <= k_s;
      idx_r    <= idx_s;
      open_r   <= open_s;
      vis_w_r  <= vis_w_s;
      margin_r <= margin_s;
    end
  end

  assign anim_state = state_r;
  assign anim_idx   = idx_r;
  assign anim_open  = open_r;
  assign vis_w      = vis_w_r;
  assign margin     = margin_r;
  assign commit     = commit_s;

endmodule

// File: rtl/card_grid_renderer.sv
// Card grid renderer: holds per-card state, runs the flip animator and
// produces the two-stage pixel pipeline (hit test, then colour select).
module card_grid_renderer
  import card_grid_pkg::*;
#(
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS,
  parameter int X0         = DEF_X0,
  parameter int Y0         = DEF_Y0,
  parameter int PITCH      = DEF_PITCH,
  parameter int CARD_W     = DEF_CARD_W,
  parameter int CARD_H     = DEF_CARD_H,
  parameter int FLIP_STEPS = DEF_FLIP_STEPS,
  parameter int RGB_W      = DEF_RGB_W,
  parameter logic [RGB_W-1:0] BACK_RGB  = 3'b100,
  parameter logic [RGB_W-1:0] MATCH_RGB = 3'b010,
  localparam int N_CARDS   = ROWS * COLS,
  localparam int IDX_W     = $clog2(N_CARDS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [9:0]                HCount,
  input  logic [9:0]                VCount,
  input  logic                      frame_tick,
  card_grid_renderer_if.slave       cmd,
  output logic [IDX_W-1:0]          rom_card,
  output logic [6:0]                rom_row,
  input  logic [CARD_W*RGB_W-1:0]   rom_data,
  output logic                      cardon,
  output logic [RGB_W-1:0]          rgb
);
  card_state_e      card_state_r [N_CARDS];
  anim_state_e      anim_state_s;
  logic [IDX_W-1:0] anim_idx_s;
  logic             anim_open_s;
  logic [9:0]       vis_w_s, margin_s;
  logic             commit_s;
  logic             accept_s, start_s, start_open_s;

  logic             hit_col_s, hit_row_s;
  logic [IDX_W-1:0] col_sel_s, row_sel_s;
  logic [6:0]       lcol_s, lrow_s;
  logic             s0_hit_r;
  logic [6:0]       s0_lcol_r;

  logic [RGB_W-1:0] face_s, rgb_s;
  logic             on_s, back_phase_s;
  logic [9:0]       lcol_w_s;

  assign cmd.cmd_ready = (anim_state_s == ANIM_IDLE);
  assign cmd.busy      = (anim_state_s != ANIM_IDLE);

  // Command decode: which accepted commands launch a flip.
  always_comb begin
    accept_s     = cmd.cmd_valid && cmd.cmd_ready;
    start_s      = 1'b0;
    start_open_s = 1'b0;
    if (accept_s) begin
      case (cmd.cmd_op)
        OP_FLIP_UP: begin
          start_s      = (card_state_r[cmd.cmd_idx] == CARD_HIDDEN);
          start_open_s = 1'b1;
        end
        OP_FLIP_DOWN: begin
          start_s      = (card_state_r[cmd.cmd_idx] == CARD_SHOWN);
          start_open_s = 1'b0;
        end
        default: begin
          start_s      = 1'b0;
          start_open_s = 1'b0;
        end
      endcase
    end else begin
      start_s = 1'b0;
    end
  end

  card_flip_anim #(
    .IDX_W      (IDX_W),
    .CARD_W     (CARD_W),
    .FLIP_STEPS (FLIP_STEPS)
  ) u_anim (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start_s),
    .start_open (start_open_s),
    .start_idx  (cmd.cmd_idx),
    .anim_state (anim_state_s),
    .anim_idx   (anim_idx_s),
    .anim_open  (anim_open_s),
    .vis_w      (vis_w_s),
    .margin     (margin_s),
    .commit     (commit_s)
  );

  // Per-card state: flip commits, clear-all and mark-matched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CARDS; i++) card_state_r[i] <= CARD_HIDDEN;
    end else if (commit_s) begin
      card_state_r[anim_idx_s] <= anim_open_s ? CARD_SHOWN : CARD_HIDDEN;
    end else if (accept_s && (cmd.cmd_op == OP_CLEAR_ALL)) begin
      for (int i = 0; i < N_CARDS; i++) card_state_r[i] <= CARD_HIDDEN;
    end else if (accept_s && (cmd.cmd_op == OP_MARK_MATCHED) &&
                 (card_state_r[cmd.cmd_idx] == CARD_SHOWN)) begin
      card_state_r[cmd.cmd_idx] <= CARD_MATCHED;
    end
  end

  // Stage 0 hit test; local offsets are taken only inside a hit range.
  always_comb begin
    hit_col_s = 1'b0;
    hit_row_s = 1'b0;
    col_sel_s = {IDX_W{1'b0}};
    row_sel_s = {IDX_W{1'b0}};
    lcol_s    = 7'd0;
    lrow_s    = 7'd0;
    for (int c = 0; c < COLS; c++) begin
      if ((HCount >= 10'(X0 + c * PITCH)) && (HCount <= 10'(X0 + c * PITCH + CARD_W - 1))) begin
        hit_col_s = 1'b1;
        col_sel_s = IDX_W'(c);
        lcol_s    = 7'(HCount - 10'(X0 + c * PITCH));
      end else begin
        hit_col_s = hit_col_s;
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if ((VCount >= 10'(Y0 + r * PITCH)) && (VCount <= 10'(Y0 + r * PITCH + CARD_H - 1))) begin
        hit_row_s = 1'b1;
        row_sel_s = IDX_W'(r);
        lrow_s    = 7'(VCount - 10'(Y0 + r * PITCH));
      end else begin
        hit_row_s = hit_row_s;
      end
    end
  end

  // Stage 0 registers; rom_card/rom_row double as the stage-0 card index and row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_hit_r  <= 1'b0;
      s0_lcol_r <= 7'd0;
      rom_card  <= {IDX_W{1'b0}};
      rom_row   <= 7'd0;
    end else if (hit_col_s && hit_row_s) begin
      s0_hit_r  <= 1'b1;
      s0_lcol_r <= lcol_s;
      rom_card  <= IDX_W'(row_sel_s * IDX_W'(COLS) + col_sel_s);
      rom_row   <= lrow_s;
    end else begin
      s0_hit_r  <= 1'b0;
      s0_lcol_r <= 7'd0;
      rom_card  <= {IDX_W{1'b0}};
      rom_row   <= 7'd0;
    end
  end

  // Stage 1 colour select from card state, animation crop and ROM pixel.
  always_comb begin
    face_s       = rom_data[int'(s0_lcol_r) * RGB_W +: RGB_W];
    lcol_w_s     = {3'b000, s0_lcol_r};
    back_phase_s = (anim_open_s && (anim_state_s == ANIM_SHRINK)) ||
                   (!anim_open_s && (anim_state_s == ANIM_GROW));
    on_s         = 1'b0;
    rgb_s        = {RGB_W{1'b0}};
    if (!s0_hit_r) begin
      on_s  = 1'b0;
      rgb_s = {RGB_W{1'b0}};
    end else if ((anim_state_s != ANIM_IDLE) && (rom_card == anim_idx_s)) begin
      if ((lcol_w_s >= margin_s) && (lcol_w_s < (margin_s + vis_w_s))) begin
        on_s  = 1'b1;
        rgb_s = back_phase_s ? BACK_RGB : face_s;
      end else begin
        on_s  = 1'b0;
        rgb_s = {RGB_W{1'b0}};
      end
    end else begin
      on_s = 1'b1;
      case (card_state_r[rom_card])
        CARD_HIDDEN:  rgb_s = BACK_RGB;
        CARD_SHOWN:   rgb_s = face_s;
        CARD_MATCHED: rgb_s = in_ring(s0_lcol_r, rom_row, CARD_W, CARD_H) ? MATCH_RGB : face_s;
        default:      rgb_s = BACK_RGB;
      endcase
    end
  end

  // Stage 1 output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cardon <= 1'b0;
      rgb    <= {RGB_W{1'b0}};
    end else begin
      cardon <= on_s;
      rgb    <= rgb_s;
    end
  end

endmodule
